fft_dit_hold2_top: RTL and testbench

- Radix-2 decimation-in-time FFT core with one shared butterfly, in-place register-file memory and two operand hold registers.
- Streams N real samples in, runs log2(N) stages of N/2 butterflies sequentially and leaves the natural-order complex spectrum in memory.
- Exposes internal FSM, address, hold and butterfly-result debug buses for bring-up and logging.

---
 rtl/fft_dit_hold2_top.sv | 163 ++++++++++++++++
 tb/tb_fft_dit_hold2_top.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_dit_hold2_top.sv
// fft_dit_hold2_top: radix-2 DIT FFT, one shared butterfly, in-place register-file memory
module fft_dit_hold2_top #(
  parameter int N = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     x_in_ext,
  output logic                      done,
  output logic [3:0]                state_dbg,
  output logic [ADDR_WIDTH-1:0]     rd_addr_dbg,
  output logic [ADDR_WIDTH-1:0]     wr_addr_dbg,
  output logic [ADDR_WIDTH-1:0]     pair_idx_dbg,
  output logic [2*DATA_WIDTH-1:0]   x0_hold_dbg,
  output logic [2*DATA_WIDTH-1:0]   x1_hold_dbg,
  output logic [2*DATA_WIDTH-1:0]   y0_dbg,
  output logic [2*DATA_WIDTH-1:0]   y1_dbg
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int PW = 2 * DW + 1;

  typedef enum logic [3:0] {
    IDLE = 4'd0, LOAD = 4'd1, INIT = 4'd2, RD0_ADDR = 4'd3, RD0_HOLD = 4'd4,
    RD1_ADDR = 4'd5, RD1_HOLD = 4'd6, BF = 4'd7, WR0 = 4'd8, WR1 = 4'd9,
    NEXT = 4'd10, DONE = 4'd11
  } state_t;

  // Twiddle constants are evaluated at elaboration with a Taylor series so no math library is needed
  function automatic logic signed [DW-1:0] trig_q(input int k, input bit sine);
    real x, term, sum, v;
    x = 6.283185307179586 * real'(k) / real'(N);
    term = sine ? x : 1.0;
    sum = term;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / (sine ? real'((2 * n) * (2 * n + 1)) : real'((2 * n - 1) * (2 * n)));
      sum = sum + term;
    end
    v = sum;
    for (int i = 0; i < DW - 2; i++) v = v * 2.0;
    return DW'(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
  endfunction

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  state_t state, state_nx;
  logic [AW-1:0] count, stage, pair;
  logic [1:0] mode_q;
  logic [2*DW-1:0] mem [N];
  logic [2*DW-1:0] rd_data, x0_hold, x1_hold, y0, y1, wdata, y0_nx, y1_nx;
  logic [AW-1:0] span, lo, i0, i1, tw_k, rd_addr, wr_addr;
  logic signed [DW-1:0] tw_re [N/2];
  logic signed [DW-1:0] tw_im [N/2];
  logic signed [DW-1:0] ar, ai, br, bi, wr, wi, tr, ti;
  logic signed [PW-1:0] pr, pi;
  logic start, we, last_pair, last_stage;

  for (genvar g = 0; g < N / 2; g++) begin : g_tw
    assign tw_re[g] = trig_q(g, 1'b0);
    assign tw_im[g] = -trig_q(g, 1'b1);
  end

  // Addressing, twiddle selection and the complex butterfly
  always_comb begin
    start = en && (mode == 2'b01 || mode == 2'b10);
    last_pair = pair == AW'(N / 2 - 1);
    last_stage = stage == AW'(AW - 1);
    span = AW'(1) << stage;
    lo = pair & (span - 1'b1);
    i0 = ((pair >> stage) << (stage + 1'b1)) | lo;
    i1 = i0 + span;
    tw_k = lo << (AW'(AW - 1) - stage);
    rd_addr = (state == RD1_ADDR || state == RD1_HOLD) ? i1 : i0;
    wr_addr = state == LOAD ? bitrev(count) : state == WR1 ? i1 : state == WR0 ? i0 : '0;
    we = (state == IDLE && start) || state == LOAD || state == WR0 || state == WR1;
    wdata = state == WR0 ? y0 : state == WR1 ? y1 : {x_in_ext, {DW{1'b0}}};
    ar = x0_hold[2*DW-1:DW];
    ai = x0_hold[DW-1:0];
    br = x1_hold[2*DW-1:DW];
    bi = x1_hold[DW-1:0];
    wr = tw_re[tw_k[AW-2:0]];
    wi = mode_q == 2'b10 ? -tw_im[tw_k[AW-2:0]] : tw_im[tw_k[AW-2:0]];
    pr = PW'(wr) * PW'(br) - PW'(wi) * PW'(bi);
    pi = PW'(wr) * PW'(bi) + PW'(wi) * PW'(br);
    tr = DW'(pr >>> (DW - 2));
    ti = DW'(pi >>> (DW - 2));
    y0_nx = {ar + tr, ai + ti};
    y1_nx = {ar - tr, ai - ti};
  end

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // Next-state sequencing: load, then per stage INIT and eight cycles per pair
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? LOAD : IDLE;
      LOAD:     state_nx = count == AW'(N - 1) ? INIT : LOAD;
      INIT:     state_nx = RD0_ADDR;
      RD0_ADDR: state_nx = RD0_HOLD;
      RD0_HOLD: state_nx = RD1_ADDR;
      RD1_ADDR: state_nx = RD1_HOLD;
      RD1_HOLD: state_nx = BF;
      BF:       state_nx = WR0;
      WR0:      state_nx = WR1;
      WR1:      state_nx = NEXT;
      NEXT:     state_nx = !last_pair ? RD0_ADDR : !last_stage ? INIT : DONE;
      DONE:     state_nx = en ? DONE : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Counters, operand hold registers and butterfly result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      stage <= '0;
      pair <= '0;
      mode_q <= '0;
      rd_data <= '0;
      x0_hold <= '0;
      x1_hold <= '0;
      y0 <= '0;
      y1 <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      case (state)
        IDLE:     if (start) begin mode_q <= mode; count <= AW'(1); end
        LOAD:     begin count <= count + 1'b1; if (count == AW'(N - 1)) stage <= '0; end
        INIT:     pair <= '0;
        RD0_HOLD: x0_hold <= rd_data;
        RD1_HOLD: x1_hold <= rd_data;
        BF:       begin y0 <= y0_nx; y1 <= y1_nx; end
        NEXT:     if (!last_pair) pair <= pair + 1'b1; else if (!last_stage) stage <= stage + 1'b1;
        default:  ;
      endcase
    end

  // In-place sample/spectrum memory
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N; i++) mem[i] <= '0;
    else if (we) mem[wr_addr] <= wdata;

  assign done = state == DONE;
  assign state_dbg = state;
  assign rd_addr_dbg = rd_addr;
  assign wr_addr_dbg = wr_addr;
  assign pair_idx_dbg = pair;
  assign x0_hold_dbg = x0_hold;
  assign x1_hold_dbg = x1_hold;
  assign y0_dbg = y0;
  assign y1_dbg = y1;
endmodule

// File: tb/tb_fft_dit_hold2_top.sv
// tb_fft_dit_hold2_top: randomized self-checking bench against a direct array FFT model
module tb_fft_dit_hold2_top;
  logic clk = 0, rst = 1, en = 0;
  logic [1:0] mode = 0;
  logic [15:0] x_in_ext = 0;
  logic done;
  logic [3:0] state_dbg, rd_addr_dbg, wr_addr_dbg, pair_idx_dbg;
  logic [31:0] x0_hold_dbg, x1_hold_dbg, y0_dbg, y1_dbg;

  int vec = 0, errs = 0;
  int xin [16];
  int mre [16];
  int mim [16];
  int wr_seq [16];
  int st_seq [16];
  logic [31:0] sx0 [2];
  logic [31:0] sx1 [2];
  logic [31:0] sy0 [2];
  logic [31:0] sy1 [2];
  int snaps, done_edge;

  fft_dit_hold2_top dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x_in_ext(x_in_ext), .done(done),
    .state_dbg(state_dbg), .rd_addr_dbg(rd_addr_dbg), .wr_addr_dbg(wr_addr_dbg),
    .pair_idx_dbg(pair_idx_dbg), .x0_hold_dbg(x0_hold_dbg), .x1_hold_dbg(x1_hold_dbg),
    .y0_dbg(y0_dbg), .y1_dbg(y1_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int br4(input int i);
    int r = 0;
    for (int b = 0; b < 4; b++) if (((i >> b) & 1) != 0) r |= 1 << (3 - b);
    return r;
  endfunction

  function automatic int w16(input longint v);
    return int'(shortint'(v));
  endfunction

  function automatic int rnd(input real v);
    return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Reference: textbook in-place DIT FFT over integer arrays with the datapath's fixed-point rules
  task automatic model(input bit inv);
    int re [16];
    int im [16];
    for (int i = 0; i < 16; i++) begin re[br4(i)] = w16(xin[i]); im[br4(i)] = 0; end
    for (int s = 0; s < 4; s++) begin
      int span = 1 << s;
      for (int g = 0; g < 16; g += 2 * span)
        for (int j = 0; j < span; j++) begin
          int a = g + j, b = g + j + span, k = j * (16 / (2 * span));
          real ang = 2.0 * 3.141592653589793 * k / 16.0;
          longint wr = rnd(16384.0 * $cos(ang));
          longint wi = inv ? rnd(16384.0 * $sin(ang)) : -rnd(16384.0 * $sin(ang));
          int tr = w16((wr * re[b] - wi * im[b]) >>> 14);
          int ti = w16((wr * im[b] + wi * re[b]) >>> 14);
          int ar = re[a], ai = im[a];
          re[a] = w16(ar + tr); im[a] = w16(ai + ti);
          re[b] = w16(ar - tr); im[b] = w16(ai - ti);
        end
    end
    for (int i = 0; i < 16; i++) begin mre[i] = re[i]; mim[i] = im[i]; end
  endtask

  // Streams xin, then runs until done (stop_edge=0) or until stop_edge clock edges have elapsed
  task automatic run_fft(input logic [1:0] md, input int stop_edge);
    int e;
    en = 1; mode = md; x_in_ext = xin[0][15:0];
    wr_seq[0] = int'(wr_addr_dbg); st_seq[0] = int'(state_dbg);
    tick(); e = 1;
    for (int i = 1; i < 16; i++) begin
      wr_seq[i] = int'(wr_addr_dbg); st_seq[i] = int'(state_dbg);
      x_in_ext = xin[i][15:0];
      tick(); e++;
    end
    x_in_ext = 0; done_edge = -1; snaps = 0;
    while (e < 400 && done_edge < 0 && (stop_edge == 0 || e < stop_edge)) begin
      if (state_dbg == 4'd9 && snaps < 2) begin
        sx0[snaps] = x0_hold_dbg; sx1[snaps] = x1_hold_dbg;
        sy0[snaps] = y0_dbg; sy1[snaps] = y1_dbg; snaps++;
      end
      tick(); e++;
      if (done) done_edge = e;
    end
    if (stop_edge == 0) begin en = 0; tick(); end
  endtask

  task automatic check_bins(input string tag);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] ex;
      ex = {mre[k][15:0], mim[k][15:0]};
      vec++;
      if (dut.mem[k] !== ex) begin
        errs++;
        $display("FAIL %s bin %0d: got %h want %h", tag, k, dut.mem[k], ex);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; mode = 0; x_in_ext = 0;
    repeat (5) tick();
    vec++; if (state_dbg !== 4'd0) begin errs++; $display("FAIL reset state: got %0d want 0", state_dbg); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset done: got %b want 0", done); end
    vec++; if ({rd_addr_dbg, wr_addr_dbg, pair_idx_dbg} !== 12'h0) begin errs++; $display("FAIL reset addr: got %h want 0", {rd_addr_dbg, wr_addr_dbg, pair_idx_dbg}); end
    vec++; if ({x0_hold_dbg, x1_hold_dbg, y0_dbg, y1_dbg} !== 128'h0) begin errs++; $display("FAIL reset hold/y: got %h want 0", {x0_hold_dbg, x1_hold_dbg, y0_dbg, y1_dbg}); end
    rst = 0; tick();
  endtask

  task automatic test_idle_modes();
    en = 1; mode = 2'b00; tick();
    vec++; if (state_dbg !== 4'd0) begin errs++; $display("FAIL idle mode00: got %0d want 0", state_dbg); end
    mode = 2'b11; tick();
    vec++; if (state_dbg !== 4'd0) begin errs++; $display("FAIL idle mode11: got %0d want 0", state_dbg); end
    en = 0; mode = 0; tick();
  endtask

  task automatic test_ramp(input string tag);
    int a [16];
    for (int i = 0; i < 16; i++) begin xin[i] = i; a[br4(i)] = i; end
    model(1'b0);
    run_fft(2'b01, 0);
    vec++; if (st_seq[0] != 0 || wr_seq[0] != 0) begin errs++; $display("FAIL %s start: got state %0d wr %0d want 0 0", tag, st_seq[0], wr_seq[0]); end
    for (int i = 1; i < 16; i++) begin
      vec++;
      if (st_seq[i] != 1 || wr_seq[i] != br4(i)) begin
        errs++; $display("FAIL %s load %0d: got state %0d wr %0d want 1 %0d", tag, i, st_seq[i], wr_seq[i], br4(i));
      end
    end
    vec++; if (done_edge != 276) begin errs++; $display("FAIL %s latency: got %0d want 276", tag, done_edge); end
    vec++; if (snaps != 2) begin errs++; $display("FAIL %s wr1 count: got %0d want 2", tag, snaps); end
    for (int p = 0; p < 2; p++) begin
      logic [31:0] e0, e1, f0, f1;
      e0 = {16'(a[2*p]), 16'h0}; e1 = {16'(a[2*p+1]), 16'h0};
      f0 = {16'(a[2*p] + a[2*p+1]), 16'h0}; f1 = {16'(a[2*p] - a[2*p+1]), 16'h0};
      vec++;
      if ({sx0[p], sx1[p], sy0[p], sy1[p]} !== {e0, e1, f0, f1}) begin
        errs++; $display("FAIL %s pair%0d bf: got %h %h %h %h want %h %h %h %h", tag, p, sx0[p], sx1[p], sy0[p], sy1[p], e0, e1, f0, f1);
      end
    end
    vec++; if (dut.mem[0] !== 32'h00780000) begin errs++; $display("FAIL %s X0: got %h want 00780000", tag, dut.mem[0]); end
    vec++; if (dut.mem[8] !== 32'hFFF80000) begin errs++; $display("FAIL %s X8: got %h want fff80000", tag, dut.mem[8]); end
    for (int k = 1; k < 16; k++) begin
      int gr = int'($signed(dut.mem[k][31:16]));
      int gi = int'($signed(dut.mem[k][15:0]));
      int ei = rnd(8.0 * $cos(3.141592653589793 * k / 16.0) / $sin(3.141592653589793 * k / 16.0));
      vec++;
      if (gr < -10 || gr > -6 || gi < ei - 2 || gi > ei + 2) begin
        errs++; $display("FAIL %s approx X%0d: got %0d,%0d want -8,%0d +-2", tag, k, gr, gi, ei);
      end
    end
    check_bins(tag);
  endtask

  task automatic test_impulse();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) xin[i] = (i == 0) ? 1 : 0;
      model(m == 1);
      run_fft(m == 1 ? 2'b10 : 2'b01, 0);
      for (int k = 0; k < 16; k++) begin
        vec++;
        if (dut.mem[k] !== 32'h00010000) begin errs++; $display("FAIL impulse m%0d bin %0d: got %h want 00010000", m, k, dut.mem[k]); end
      end
      check_bins(m == 1 ? "impulse_inv_model" : "impulse_fwd_model");
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bit inv = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 16; i++) xin[i] = int'($urandom_range(0, 8191)) - 4096;
      model(inv);
      run_fft(inv ? 2'b10 : 2'b01, 0);
      vec++; if (done_edge != 276) begin errs++; $display("FAIL random%0d latency: got %0d want 276", r, done_edge); end
      check_bins($sformatf("random%0d", r));
    end
  endtask

  task automatic test_abort();
    int nz = 0;
    for (int i = 0; i < 16; i++) xin[i] = i;
    run_fft(2'b01, 170);
    vec++; if (state_dbg < 4'd2 || state_dbg > 4'd10) begin errs++; $display("FAIL abort precondition: got state %0d want 2..10", state_dbg); end
    rst = 1; en = 0; mode = 0;
    #2;
    vec++; if (state_dbg !== 4'd0 || done !== 1'b0) begin errs++; $display("FAIL abort state: got %0d/%b want 0/0", state_dbg, done); end
    vec++; if ({rd_addr_dbg, wr_addr_dbg, pair_idx_dbg, x0_hold_dbg, x1_hold_dbg, y0_dbg, y1_dbg} !== 140'h0) begin
      errs++; $display("FAIL abort debug: got %h %h %h want 0", pair_idx_dbg, y0_dbg, y1_dbg);
    end
    for (int k = 0; k < 16; k++) if (dut.mem[k] != 0) nz++;
    vec++; if (nz != 0) begin errs++; $display("FAIL abort mem: got %0d nonzero want 0", nz); end
    tick(); rst = 0; tick();
    test_ramp("ramp_after_abort");
  endtask

  initial begin
    test_reset();
    test_idle_modes();
    test_ramp("ramp");
    test_impulse();
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
